// File: rtl/max31855_pkg.sv
// rtl/max31855_pkg.sv - shared states, frame layout and helpers for the MAX31855 scanner
package max31855_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam int FRAME_BITS  = 32;
    localparam int TC_MSB      = 31;
    localparam int TC_LSB      = 18;
    localparam int RSVD_HI_BIT = 17;
    localparam int FAULT_BIT   = 16;
    localparam int IC_MSB      = 15;
    localparam int IC_LSB      = 4;
    localparam int RSVD_LO_BIT = 3;

    // An absent converter leaves MISO pulled high for the whole frame.
    localparam logic [31:0] NO_DEVICE = 32'hFFFF_FFFF;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/max31855_frame_rx.sv
// rtl/max31855_frame_rx.sv - one CS-low frame: setup, 32 SPI bits MSB first, hold
module max31855_frame_rx
    import max31855_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        miso,
    output logic        sclk,
    output logic        done,
    output logic [31:0] frame
);

    localparam int            DW       = clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    state_t        phase_q, phase_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic          sclk_q, sclk_d;
    logic [31:0]   shift_q, shift_d;
    logic          div_end;

    assign div_end = (cnt_q == DIV_LAST);
    // done is combinational so the top can raise CS on the very edge the hold phase ends
    assign done    = (phase_q == ST_HOLD) && div_end;
    assign sclk    = sclk_q;
    assign frame   = shift_q;

    // Phase sequencing: SETUP and HOLD are one divider period each, SHIFT is 32 low/high pairs
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        shift_d = shift_q;
        case (phase_q)
            ST_SETUP: begin
                if (div_end) begin
                    cnt_d   = '0;
                    phase_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_end) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        // Sample on the edge where SCLK is driven high
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[30:0], miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 5'(FRAME_BITS - 1)) begin
                            phase_d = ST_HOLD;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (div_end) begin
                    cnt_d   = '0;
                    phase_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (start) begin
                    phase_d = ST_SETUP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                end
            end
        endcase
    end

    // Frame state registers; reset drops SCLK immediately and discards the partial frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            shift_q <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/max31855_scanner.sv
// rtl/max31855_scanner.sv - multi-channel MAX31855 reader: channel sequencing, gap, decode, error mask
module max31855_scanner
    import max31855_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int CLK_DIV    = 25,
    parameter int GAP_CYCLES = 900,
    localparam int CHW       = (clog2(N_CH) > 1) ? clog2(N_CH) : 1
) (
    input  logic            SYSCLK,
    input  logic            RST,
    input  logic            READ,
    input  logic            AUTO,
    input  logic            SPI_MISO,
    output logic            SPI_CLK,
    output logic [N_CH-1:0] SPI_CS,
    output logic            BUSY_FLAG,
    output logic            DATA_VALID,
    output logic [CHW-1:0]  CH_ID,
    output logic [13:0]     TEMPERATURE_TC,
    output logic [11:0]     TEMPERATURE_IC,
    output logic [2:0]      FAULT,
    output logic            FAULT_ANY,
    output logic            FRAME_ERR,
    output logic [N_CH-1:0] ERROR_MASK
);

    localparam int             GW       = clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [CHW-1:0] CH_LAST  = CHW'(N_CH - 1);

    function automatic logic [N_CH-1:0] cs_select(input logic [CHW-1:0] ch);
        return ~(N_CH'(1) << ch);
    endfunction

    // ST_SETUP here covers the whole CS-low frame; frame_rx runs SETUP/SHIFT/HOLD inside it
    state_t          state_q, state_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [N_CH-1:0] cs_q, cs_d;
    logic            busy_q, busy_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            pend_q, pend_d;
    logic            dv_q, dv_d;
    logic [CHW-1:0]  ch_id_q, ch_id_d;
    logic [13:0]     tc_q, tc_d;
    logic [11:0]     ic_q, ic_d;
    logic [2:0]      fault_q, fault_d;
    logic            fault_any_q, fault_any_d;
    logic            frame_err_q, frame_err_d;
    logic [N_CH-1:0] mask_q, mask_d;

    logic        rx_start;
    logic        rx_done;
    logic        rx_sclk;
    logic [31:0] rx_frame;
    logic        dec_fault_any;
    logic        dec_frame_err;

    max31855_frame_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_frame_rx (
        .clk   (SYSCLK),
        .rst   (RST),
        .start (rx_start),
        .miso  (SPI_MISO),
        .sclk  (rx_sclk),
        .done  (rx_done),
        .frame (rx_frame)
    );

    // rx_frame stays put until the next frame's first SCLK rise, well after the decode cycle
    assign dec_fault_any = rx_frame[FAULT_BIT];
    assign dec_frame_err = rx_frame[RSVD_HI_BIT] | rx_frame[RSVD_LO_BIT] | (rx_frame == NO_DEVICE);

    // Scan sequencing plus the one-cycle-late decode of each completed frame
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cs_d        = cs_q;
        busy_d      = busy_q;
        gap_cnt_d   = gap_cnt_q;
        pend_d      = 1'b0;
        dv_d        = 1'b0;
        ch_id_d     = ch_id_q;
        tc_d        = tc_q;
        ic_d        = ic_q;
        fault_d     = fault_q;
        fault_any_d = fault_any_q;
        frame_err_d = frame_err_q;
        mask_d      = mask_q;
        rx_start    = 1'b0;

        if (pend_q) begin
            dv_d         = 1'b1;
            ch_id_d      = ch_q;
            tc_d         = rx_frame[TC_MSB:TC_LSB];
            ic_d         = rx_frame[IC_MSB:IC_LSB];
            fault_d      = rx_frame[2:0];
            fault_any_d  = dec_fault_any;
            frame_err_d  = dec_frame_err;
            mask_d[ch_q] = dec_fault_any | dec_frame_err;
        end

        case (state_q)
            ST_SETUP: begin
                if (rx_done) begin
                    cs_d      = '1;
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                    pend_d    = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (ch_q != CH_LAST) begin
                        ch_d     = ch_q + 1'b1;
                        cs_d     = cs_select(ch_q + 1'b1);
                        rx_start = 1'b1;
                        state_d  = ST_SETUP;
                    end else if (AUTO) begin
                        ch_d     = '0;
                        cs_d     = cs_select('0);
                        rx_start = 1'b1;
                        state_d  = ST_SETUP;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                if (READ || AUTO) begin
                    ch_d     = '0;
                    busy_d   = 1'b1;
                    cs_d     = cs_select('0);
                    rx_start = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
        endcase
    end

    // Scanner state and registered outputs; reset releases every CS at once
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            cs_q        <= '1;
            busy_q      <= 1'b0;
            gap_cnt_q   <= '0;
            pend_q      <= 1'b0;
            dv_q        <= 1'b0;
            ch_id_q     <= '0;
            tc_q        <= '0;
            ic_q        <= '0;
            fault_q     <= '0;
            fault_any_q <= 1'b0;
            frame_err_q <= 1'b0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cs_q        <= cs_d;
            busy_q      <= busy_d;
            gap_cnt_q   <= gap_cnt_d;
            pend_q      <= pend_d;
            dv_q        <= dv_d;
            ch_id_q     <= ch_id_d;
            tc_q        <= tc_d;
            ic_q        <= ic_d;
            fault_q     <= fault_d;
            fault_any_q <= fault_any_d;
            frame_err_q <= frame_err_d;
            mask_q      <= mask_d;
        end
    end

    assign SPI_CLK        = rx_sclk;
    assign SPI_CS         = cs_q;
    assign BUSY_FLAG      = busy_q;
    assign DATA_VALID     = dv_q;
    assign CH_ID          = ch_id_q;
    assign TEMPERATURE_TC = tc_q;
    assign TEMPERATURE_IC = ic_q;
    assign FAULT          = fault_q;
    assign FAULT_ANY      = fault_any_q;
    assign FRAME_ERR      = frame_err_q;
    assign ERROR_MASK     = mask_q;

endmodule

// File: tb/tb_max31855_scanner.sv
// tb/tb_max31855_scanner.sv - scoreboard bench for max31855_scanner with randomized device frames
module tb_max31855_scanner;

    localparam int N_CH       = 4;
    localparam int CLK_DIV    = 2;
    localparam int GAP_CYCLES = 4;
    localparam int FRAME_LOW  = 66 * CLK_DIV;
    localparam int PERIOD     = FRAME_LOW + GAP_CYCLES;
    localparam int SCAN       = N_CH * PERIOD;

    logic            SYSCLK = 1'b0;
    logic            RST = 1'b1;
    logic            READ = 1'b0;
    logic            AUTO = 1'b0;
    logic            SPI_MISO = 1'b1;
    logic            SPI_CLK;
    logic [N_CH-1:0] SPI_CS;
    logic            BUSY_FLAG;
    logic            DATA_VALID;
    logic [1:0]      CH_ID;
    logic [13:0]     TEMPERATURE_TC;
    logic [11:0]     TEMPERATURE_IC;
    logic [2:0]      FAULT;
    logic            FAULT_ANY;
    logic            FRAME_ERR;
    logic [N_CH-1:0] ERROR_MASK;

    max31855_scanner #(
        .N_CH       (N_CH),
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .SYSCLK         (SYSCLK),
        .RST            (RST),
        .READ           (READ),
        .AUTO           (AUTO),
        .SPI_MISO       (SPI_MISO),
        .SPI_CLK        (SPI_CLK),
        .SPI_CS         (SPI_CS),
        .BUSY_FLAG      (BUSY_FLAG),
        .DATA_VALID     (DATA_VALID),
        .CH_ID          (CH_ID),
        .TEMPERATURE_TC (TEMPERATURE_TC),
        .TEMPERATURE_IC (TEMPERATURE_IC),
        .FAULT          (FAULT),
        .FAULT_ANY      (FAULT_ANY),
        .FRAME_ERR      (FRAME_ERR),
        .ERROR_MASK     (ERROR_MASK)
    );

    always #5 SYSCLK = ~SYSCLK;

    typedef struct {
        int              ch;
        logic [13:0]     tc;
        logic [11:0]     ic;
        logic [2:0]      fault;
        logic            fa;
        logic            fe;
        logic [N_CH-1:0] mask;
    } exp_t;

    exp_t            exp_q[$];
    logic [31:0]     dev_word[N_CH];
    logic [N_CH-1:0] model_mask = '0;
    int              checks = 0;
    int              errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: decode a device word into the expected report
    task automatic push_frame(input int c);
        exp_t        e;
        logic [31:0] w;
        w       = dev_word[c];
        e.ch    = c;
        e.tc    = 14'(w / (2 ** 18));
        e.ic    = 12'((w / 16) % 4096);
        e.fault = 3'(w % 8);
        e.fa    = ((w / (2 ** 16)) % 2) == 1;
        e.fe    = (((w / (2 ** 17)) % 2) == 1) || (((w / 8) % 2) == 1) || (w == 32'hFFFF_FFFF);
        model_mask[c] = e.fa | e.fe;
        e.mask  = model_mask;
        exp_q.push_back(e);
    endtask

    task automatic push_scan();
        for (int c = 0; c < N_CH; c++) push_frame(c);
    endtask

    function automatic logic [31:0] clean_word();
        logic [31:0] w;
        w = $urandom;
        w = w & ~32'h0003_0008;
        return w;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        case ($urandom_range(0, 4))
            0:       w = 32'hFFFF_FFFF;
            1:       w = clean_word() | 32'h0001_0000;
            2:       w = $urandom;
            default: w = clean_word();
        endcase
        return w;
    endfunction

    // Device model: MSB presented on CS fall, next bit after each SCLK rise
    logic [N_CH-1:0] cs_prev = '1;
    logic            clk_prev = 1'b0;
    int              nbits = 0;
    always @(negedge SYSCLK) begin
        if (SPI_CS != cs_prev) nbits = 0;
        else if (SPI_CLK && !clk_prev && nbits < 32) nbits++;
        cs_prev  = SPI_CS;
        clk_prev = SPI_CLK;
        SPI_MISO = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            if (!SPI_CS[c] && nbits < 32) SPI_MISO = dev_word[c][31 - nbits];
        end
    end

    // Monitor: frame timing plus scoreboard pop on every strobe
    int cyc = 0;
    int low_cnt = 0;
    int last_fall = 0;
    bit have_fall = 0;
    bit prev_low = 0;
    bit dv_due = 0;
    always @(negedge SYSCLK) begin
        exp_t e;
        cyc++;
        if (RST) begin
            low_cnt   = 0;
            have_fall = 0;
            prev_low  = 0;
            dv_due    = 0;
        end else begin
            if (dv_due) begin
                chk("dv_one_cycle_after_cs_rise", DATA_VALID, 1);
                dv_due = 0;
            end
            chk("cs_at_most_one_low", ($countones(~SPI_CS) <= 1), 1);
            if (SPI_CS != '1) begin
                if (!prev_low) begin
                    if (have_fall) chk("channel_period", cyc - last_fall, PERIOD);
                    have_fall = 1;
                    last_fall = cyc;
                    low_cnt   = 0;
                end
                low_cnt++;
            end else if (prev_low) begin
                chk("cs_low_length", low_cnt, FRAME_LOW);
                dv_due = 1;
            end
            prev_low = (SPI_CS != '1);
            if (!BUSY_FLAG) have_fall = 0;
            if (DATA_VALID) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got DATA_VALID=1 ch %0d expected no strobe", CH_ID);
                end else begin
                    e = exp_q.pop_front();
                    chk("ch_id", CH_ID, e.ch);
                    chk("temperature_tc", TEMPERATURE_TC, e.tc);
                    chk("temperature_ic", TEMPERATURE_IC, e.ic);
                    chk("fault", FAULT, e.fault);
                    chk("fault_any", FAULT_ANY, e.fa);
                    chk("frame_err", FRAME_ERR, e.fe);
                    chk("error_mask", ERROR_MASK, e.mask);
                end
            end
        end
    end

    task automatic pulse_read();
        @(negedge SYSCLK);
        READ = 1'b1;
        @(negedge SYSCLK);
        READ = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge SYSCLK);
        while (BUSY_FLAG !== 1'b0 && n < budget) begin
            @(negedge SYSCLK);
            n++;
        end
        chk(name, BUSY_FLAG, 0);
        repeat (3) @(negedge SYSCLK);
    endtask

    task automatic run_scan(input string name);
        push_scan();
        pulse_read();
        wait_idle(SCAN + 50, name);
    endtask

    initial begin
        int n;
        for (int c = 0; c < N_CH; c++) dev_word[c] = 32'h0640_1900;

        repeat (3) @(posedge SYSCLK);
        #1;
        chk("rst_cs", SPI_CS, 4'hF);
        chk("rst_sclk", SPI_CLK, 0);
        chk("rst_busy", BUSY_FLAG, 0);
        chk("rst_dv", DATA_VALID, 0);
        chk("rst_ch_id", CH_ID, 0);
        chk("rst_tc", TEMPERATURE_TC, 0);
        chk("rst_ic", TEMPERATURE_IC, 0);
        chk("rst_fault", {FAULT, FAULT_ANY, FRAME_ERR}, 0);
        chk("rst_mask", ERROR_MASK, 0);
        @(negedge SYSCLK);
        RST = 1'b0;
        repeat (2) @(negedge SYSCLK);

        // Nominal scan with read-to-CS latency check
        push_scan();
        READ = 1'b1;
        @(posedge SYSCLK);
        #1;
        chk("read_to_cs0", SPI_CS, 4'b1110);
        chk("read_to_busy", BUSY_FLAG, 1);
        @(negedge SYSCLK);
        READ = 1'b0;
        wait_idle(SCAN + 50, "scan_nominal_done");

        // Negative temperatures and a fault on ch2, then ch2 clean again
        dev_word[0] = clean_word();
        dev_word[1] = 32'hFFFC_FF00;
        dev_word[2] = 32'h0001_0001;
        dev_word[3] = clean_word();
        run_scan("scan_negative_fault_done");
        dev_word[2] = clean_word();
        run_scan("scan_recover_done");

        // No device anywhere
        for (int c = 0; c < N_CH; c++) dev_word[c] = 32'hFFFF_FFFF;
        run_scan("scan_no_device_done");

        // Randomized scans
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < N_CH; c++) dev_word[c] = rand_word();
            run_scan("scan_random_done");
        end

        // AUTO for 2.5 scans with ignored READ pulses
        for (int c = 0; c < N_CH; c++) dev_word[c] = rand_word();
        for (int s = 0; s < 3; s++) push_scan();
        @(negedge SYSCLK);
        AUTO = 1'b1;
        for (int i = 0; i < (5 * SCAN) / 2; i++) begin
            @(negedge SYSCLK);
            READ = ((i % 300) == 150);
        end
        READ = 1'b0;
        AUTO = 1'b0;
        wait_idle(2 * SCAN, "auto_stop_done");
        chk("auto_frames_consumed", exp_q.size(), 0);

        // Reset in the middle of ch1's shift
        for (int c = 0; c < N_CH; c++) dev_word[c] = rand_word();
        push_scan();
        pulse_read();
        n = 0;
        while (SPI_CS !== 4'b1101 && n < 2 * PERIOD) begin
            @(negedge SYSCLK);
            n++;
        end
        chk("reach_ch1", SPI_CS, 4'b1101);
        repeat (20) @(negedge SYSCLK);
        @(posedge SYSCLK);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_async_cs", SPI_CS, 4'hF);
        chk("rst_async_sclk", SPI_CLK, 0);
        chk("rst_pending_frames", exp_q.size(), N_CH - 1);
        exp_q.delete();
        model_mask = '0;
        repeat (3) @(negedge SYSCLK);
        chk("rst_hold_dv", DATA_VALID, 0);
        chk("rst_hold_mask", ERROR_MASK, 0);
        RST = 1'b0;
        repeat (20) @(negedge SYSCLK);
        chk("post_rst_idle", BUSY_FLAG, 0);
        for (int c = 0; c < N_CH; c++) dev_word[c] = rand_word();
        push_scan();
        READ = 1'b1;
        @(posedge SYSCLK);
        #1;
        chk("restart_cs0", SPI_CS, 4'b1110);
        @(negedge SYSCLK);
        READ = 1'b0;
        wait_idle(SCAN + 50, "restart_scan_done");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
